// File: rtl/activation_unit.sv
// activation_unit: lane-parallel ReLU / leaky / clamp / bypass activation stage.
// Define ACT_ZERO_COUNT_EN to add the zero_count output and its counter.
module activation_unit #(
   parameter int DATAWIDTH  = 11,
   parameter int ROWS       = 4,
   parameter int LANES      = 2,
   parameter int LEAK_SHIFT = 3,
   parameter int CLAMP_MAX  = 127
) (
   input  logic                      clk,
   input  logic                      rst_overall,
   input  logic                      rst_vals,
   input  logic                      layer_done,
   input  logic [1:0]                mode,
   input  logic [ROWS*DATAWIDTH-1:0] in,
   output logic [ROWS*DATAWIDTH-1:0] out,
   output logic                      busy,
   output logic                      done
`ifdef ACT_ZERO_COUNT_EN
   ,
   output logic [$clog2(ROWS+1)-1:0] zero_count
`endif
);

   localparam int BEATS = (ROWS + LANES - 1) / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int VW    = ROWS * DATAWIDTH;
   localparam logic signed [DATAWIDTH-1:0] CMAX = DATAWIDTH'(CLAMP_MAX);
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [BW-1:0] beat_q;
   logic [VW-1:0] buf_q;
   logic [VW-1:0] out_q;
   logic [VW-1:0] out_nxt;
   logic [1:0]    mode_q;
   logic          done_q;
   logic          last_beat;

`ifdef ACT_ZERO_COUNT_EN
   localparam int ZW = $clog2(ROWS + 1);
   logic [ZW-1:0] zc_q;
   logic [ZW-1:0] zc_inc;
`endif

   function automatic logic signed [DATAWIDTH-1:0] act(
      input logic signed [DATAWIDTH-1:0] x,
      input logic [1:0]                  m
   );
      logic signed [DATAWIDTH-1:0] r;
      r = x;
      unique case (m)
         2'd0: r = x[DATAWIDTH-1] ? '0 : x;
         2'd1: r = x[DATAWIDTH-1] ? (x >>> LEAK_SHIFT) : x;
         2'd2: begin
            if (x[DATAWIDTH-1])
               r = '0;
            else if (x > CMAX)
               r = CMAX;
            else
               r = x;
         end
         2'd3: r = x;
      endcase
      return r;
   endfunction

   assign last_beat = (beat_q == LAST);

   // Lanes of the current beat; indices past ROWS on a partial beat drop out.
   always_comb begin
      int idx;
      logic signed [DATAWIDTH-1:0] r;
      out_nxt = out_q;
`ifdef ACT_ZERO_COUNT_EN
      zc_inc = '0;
`endif
      for (int l = 0; l < LANES; l++) begin
         idx = int'(beat_q) * LANES + l;
         r   = '0;
         if (idx < ROWS) begin
            r = act(buf_q[idx*DATAWIDTH +: DATAWIDTH], mode_q);
            out_nxt[idx*DATAWIDTH +: DATAWIDTH] = r;
`ifdef ACT_ZERO_COUNT_EN
            if (r == '0)
               zc_inc = zc_inc + ZW'(1);
`endif
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (layer_done) state_d = S_RUN;
         S_RUN:   if (last_beat) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (rst_vals)
         state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst_overall) begin
      if (rst_overall)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst_overall) begin
      if (rst_overall) begin
         beat_q <= '0;
         buf_q  <= '0;
         out_q  <= '0;
         mode_q <= '0;
         done_q <= 1'b0;
`ifdef ACT_ZERO_COUNT_EN
         zc_q   <= '0;
`endif
      end else if (rst_vals) begin
         beat_q <= '0;
         buf_q  <= '0;
         out_q  <= '0;
         mode_q <= '0;
         done_q <= 1'b0;
`ifdef ACT_ZERO_COUNT_EN
         zc_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (layer_done) begin
                  buf_q  <= in;
                  mode_q <= mode;
                  beat_q <= '0;
`ifdef ACT_ZERO_COUNT_EN
                  zc_q   <= '0;
`endif
               end
            end
            S_RUN: begin
               out_q  <= out_nxt;
               beat_q <= beat_q + BW'(1);
`ifdef ACT_ZERO_COUNT_EN
               zc_q   <= zc_q + zc_inc;
`endif
               if (last_beat)
                  done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign busy = (state_q != S_IDLE);
`ifdef ACT_ZERO_COUNT_EN
   assign zero_count = zc_q;
`endif

endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: randomized and directed checks of activation_unit
// against an arithmetic reference model.
module tb_activation_unit;

   localparam int DW   = 11;
   localparam int LEAK = 3;
   localparam int CMAX = 127;

   logic clk = 1'b0;
   logic rst_overall = 1'b1;
   logic rst_vals = 1'b0;
   logic layer_done = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [4*DW-1:0] in_v = '0;
   logic [4*DW-1:0] out_v;
   logic busy, done;

   logic layer_done5 = 1'b0;
   logic [1:0] mode5 = 2'd0;
   logic [5*DW-1:0] in5 = '0;
   logic [5*DW-1:0] out5;
   logic busy5, done5;

`ifdef ACT_ZERO_COUNT_EN
   logic [2:0] zero_count;
   logic [2:0] zero_count5;
`endif

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   activation_unit #(
      .DATAWIDTH(DW), .ROWS(4), .LANES(2),
      .LEAK_SHIFT(LEAK), .CLAMP_MAX(CMAX)
   ) dut (
      .clk(clk), .rst_overall(rst_overall), .rst_vals(rst_vals),
      .layer_done(layer_done), .mode(mode), .in(in_v),
      .out(out_v), .busy(busy), .done(done)
`ifdef ACT_ZERO_COUNT_EN
      , .zero_count(zero_count)
`endif
   );

   activation_unit #(
      .DATAWIDTH(DW), .ROWS(5), .LANES(2),
      .LEAK_SHIFT(LEAK), .CLAMP_MAX(CMAX)
   ) dut5 (
      .clk(clk), .rst_overall(rst_overall), .rst_vals(rst_vals),
      .layer_done(layer_done5), .mode(mode5), .in(in5),
      .out(out5), .busy(busy5), .done(done5)
`ifdef ACT_ZERO_COUNT_EN
      , .zero_count(zero_count5)
`endif
   );

   // Leaky slope uses floor division, written without shifts.
   function automatic int ref_act(input int x, input int m);
      int d;
      d = 1 << LEAK;
      case (m)
         0: return (x < 0) ? 0 : x;
         1: return (x < 0) ? (x - (d - 1)) / d : x;
         2: return (x < 0) ? 0 : ((x > CMAX) ? CMAX : x);
         default: return x;
      endcase
   endfunction

   function automatic int rnd_elem();
      int edges[8] = '{-1024, 1023, -1, 0, 127, 128, -8, -9};
      if ($urandom_range(0, 3) == 0)
         return edges[$urandom_range(0, 7)];
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   task automatic run_vec(
      input  logic [4*DW-1:0] v,
      input  logic [1:0]      m,
      output logic [4*DW-1:0] got,
      output int              lat,
      output logic            pulse_ok,
      output int              zc
   );
      @(negedge clk);
      in_v = v;
      mode = m;
      layer_done = 1'b1;
      @(posedge clk);
      #1;
      layer_done = 1'b0;
      lat = -1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = e;
            break;
         end
      end
      got = out_v;
      zc = -1;
`ifdef ACT_ZERO_COUNT_EN
      zc = int'(zero_count);
`endif
      @(posedge clk);
      #1;
      pulse_ok = !done;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (out_v !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async out=%h busy=%b done=%b want 0/0/0",
                  out_v, busy, done);
      end
`ifdef ACT_ZERO_COUNT_EN
      n_checks++;
      if (zero_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_zc got %0d want 0", zero_count);
      end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_overall = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out5 !== '0 || busy5 !== 1'b0 || done5 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut5 out=%h busy=%b done=%b want 0/0/0",
                  out5, busy5, done5);
      end
   endtask

   task automatic test_directed();
      int dv[5][4] = '{'{-15, 5, -2, 20}, '{-15, 5, -2, -1},
                       '{-15, 5, -2, -1}, '{200, -3, 127, 50},
                       '{0, -1, 7, -8}};
      int ev[5][4] = '{'{0, 5, 0, 20}, '{-2, 5, -1, -1},
                       '{-15, 5, -2, -1}, '{127, 0, 127, 50},
                       '{0, 0, 7, 0}};
      int dm[5] = '{0, 1, 3, 2, 0};
      int ez[5] = '{2, 0, 0, 1, 3};
      logic [4*DW-1:0] v, ex, got;
      int lat, zc;
      logic pok;
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 4; i++) begin
            v[i*DW +: DW]  = DW'(dv[t][i]);
            ex[i*DW +: DW] = DW'(ev[t][i]);
         end
         run_vec(v, 2'(dm[t]), got, lat, pok, zc);
         n_checks++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL dir%0d_out got %h want %h", t, got, ex);
         end
         n_checks++;
         if (lat !== 2) begin
            n_fail++;
            $display("FAIL dir%0d_latency got %0d want 2", t, lat);
         end
         n_checks++;
         if (pok !== 1'b1) begin
            n_fail++;
            $display("FAIL dir%0d_pulse done stayed high got %b want 1", t, pok);
         end
`ifdef ACT_ZERO_COUNT_EN
         n_checks++;
         if (zc !== ez[t]) begin
            n_fail++;
            $display("FAIL dir%0d_zc got %0d want %0d", t, zc, ez[t]);
         end
`endif
      end
   endtask

   task automatic test_random();
      logic [4*DW-1:0] v, ex, got;
      int lat, zc, x, m, r, nz;
      logic pok;
      for (int t = 0; t < 40; t++) begin
         m = int'($urandom_range(0, 3));
         nz = 0;
         for (int i = 0; i < 4; i++) begin
            x = rnd_elem();
            r = ref_act(x, m);
            if (r == 0) nz++;
            v[i*DW +: DW]  = DW'(x);
            ex[i*DW +: DW] = DW'(r);
         end
         run_vec(v, 2'(m), got, lat, pok, zc);
         n_checks++;
         if (got !== ex || lat !== 2 || pok !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d m=%0d out %h lat %0d pulse %b want %h 2 1",
                     t, m, got, lat, pok, ex);
         end
`ifdef ACT_ZERO_COUNT_EN
         n_checks++;
         if (zc !== nz) begin
            n_fail++;
            $display("FAIL rand%0d_zc got %0d want %0d", t, zc, nz);
         end
`endif
      end
   endtask

   task automatic test_rows5();
      logic [5*DW-1:0] ex;
      int x, m, r, nz, lat;
      for (int t = 0; t < 6; t++) begin
         m = (t == 0) ? 0 : int'($urandom_range(0, 3));
         nz = 0;
         for (int i = 0; i < 5; i++) begin
            x = (t == 0) ? ((i % 2 == 0) ? -(i + 1) : (i + 1)) : rnd_elem();
            r = ref_act(x, m);
            if (r == 0) nz++;
            in5[i*DW +: DW] = DW'(x);
            ex[i*DW +: DW]  = DW'(r);
         end
         @(negedge clk);
         mode5 = 2'(m);
         layer_done5 = 1'b1;
         @(posedge clk);
         #1;
         layer_done5 = 1'b0;
         lat = -1;
         for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done5) begin
               lat = e;
               break;
            end
         end
         n_checks++;
         if (out5 !== ex || lat !== 3) begin
            n_fail++;
            $display("FAIL rows5_%0d out %h lat %0d want %h 3",
                     t, out5, lat, ex);
         end
`ifdef ACT_ZERO_COUNT_EN
         n_checks++;
         if (int'(zero_count5) !== nz) begin
            n_fail++;
            $display("FAIL rows5_%0d_zc got %0d want %0d", t, zero_count5, nz);
         end
`endif
         @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int a[4] = '{-7, 100, -300, 9};
      int b[4] = '{3, -4, 5, -6};
      logic [4*DW-1:0] va, vb, ea;
      int e1, e2;
      for (int i = 0; i < 4; i++) begin
         va[i*DW +: DW] = DW'(a[i]);
         vb[i*DW +: DW] = DW'(b[i]);
         ea[i*DW +: DW] = DW'(ref_act(a[i], 0));
      end
      @(negedge clk);
      in_v = va;
      mode = 2'd0;
      layer_done = 1'b1;
      @(posedge clk);
      #1;
      in_v = vb;
      mode = 2'd3;
      e1 = -1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            e1 = e;
            break;
         end
      end
      n_checks++;
      if (out_v !== ea || e1 !== 2) begin
         n_fail++;
         $display("FAIL hold_first out %h lat %0d want %h 2", out_v, e1, ea);
      end
      e2 = -1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            e2 = e;
            break;
         end
      end
      layer_done = 1'b0;
      n_checks++;
      if (out_v !== vb || e2 !== 4) begin
         n_fail++;
         $display("FAIL hold_second out %h gap %0d want %h 4", out_v, e2, vb);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_idle busy got %b want 0", busy);
      end
   endtask

   task automatic test_rst_vals();
      logic [4*DW-1:0] v, got;
      int lat, zc;
      logic pok, seen;
      for (int i = 0; i < 4; i++) v[i*DW +: DW] = DW'(i + 11);
      run_vec(v, 2'd3, got, lat, pok, zc);
      @(negedge clk);
      in_v = ~v;
      layer_done = 1'b1;
      @(posedge clk);
      #1;
      layer_done = 1'b0;
      @(negedge clk);
      rst_vals = 1'b1;
      @(posedge clk);
      #1;
      rst_vals = 1'b0;
      n_checks++;
      if (out_v !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_vals_clear out=%h busy=%b done=%b want 0/0/0",
                  out_v, busy, done);
      end
`ifdef ACT_ZERO_COUNT_EN
      n_checks++;
      if (zero_count !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_vals_zc got %0d want 0", zero_count);
      end
`endif
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_vals_abort activity got %b want 0", seen);
      end
      @(negedge clk);
      layer_done = 1'b1;
      rst_vals = 1'b1;
      @(posedge clk);
      #1;
      layer_done = 1'b0;
      rst_vals = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_vals_priority busy got %b want 0", busy);
      end
   endtask

   task automatic test_async_reset();
      logic [4*DW-1:0] v, got;
      int lat, zc;
      logic pok;
      for (int i = 0; i < 4; i++) v[i*DW +: DW] = DW'(-(i + 50));
      run_vec(v, 2'd3, got, lat, pok, zc);
      @(negedge clk);
      layer_done = 1'b1;
      @(posedge clk);
      #1;
      layer_done = 1'b0;
      @(posedge clk);
      #2;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL async_pre busy got %b want 1", busy);
      end
      rst_overall = 1'b1;
      #1;
      n_checks++;
      if (out_v !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst out=%h busy=%b done=%b want 0/0/0",
                  out_v, busy, done);
      end
      @(negedge clk);
      rst_overall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_rows5();
      test_back_to_back();
      test_rst_vals();
      test_async_reset();
      test_directed();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
